int_axis_block_averager: RTL and testbench

//  Downstream consumer of the float-to-int converter's AXI-Stream output (32-bit two's complement).

---
 rtl/int_axis_block_averager_pkg.sv | 12 +
 rtl/int_axis_block_averager.sv | 88 ++++++++
 tb/tb_int_axis_block_averager.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/int_axis_block_averager_pkg.sv
// Shared definitions for the integer AXI-Stream block averager.
// The sample width must match the float-to-int converter's output stream.
package int_axis_block_averager_pkg;

  localparam int unsigned AXIS_DATA_W = 32;

  // A sum of 2**log2_n sign-extended samples needs log2_n extra bits.
  function automatic int unsigned acc_width(input int unsigned log2_n);
    return AXIS_DATA_W + log2_n;
  endfunction

endpackage

// File: rtl/int_axis_block_averager.sv
// Sums blocks of 2**LOG2_N signed samples and emits the floored mean on an AXI-Stream master.
// The output register lets the next block start filling while a mean waits for downstream.
module int_axis_block_averager
  import int_axis_block_averager_pkg::*;
#(
  parameter int unsigned DATA_W = AXIS_DATA_W,
  parameter int unsigned LOG2_N = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              clear,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [LOG2_N-1:0] blk_cnt
);

  // Follows DATA_W if it is ever overridden away from the shared stream width.
  localparam int unsigned ACC_W = acc_width(LOG2_N) + DATA_W - AXIS_DATA_W;
  localparam logic [LOG2_N-1:0] CNT_LAST = '1;
  localparam logic [LOG2_N-1:0] CNT_ONE  = LOG2_N'(1);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  sample_ext;
  logic [ACC_W-1:0]  sum;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last;
  logic              in_hs;
  logic              out_hs;

  assign last       = (cnt_q == CNT_LAST);
  assign sample_ext = {{LOG2_N{s_axis_tdata[DATA_W-1]}}, s_axis_tdata};
  assign sum        = acc_q + sample_ext;

  // Only the completing sample must wait for a pending mean to drain.
  assign s_axis_tready = ~(last & valid_q & ~m_axis_tready);
  assign in_hs         = s_axis_tvalid & s_axis_tready;
  assign out_hs        = valid_q & m_axis_tready;

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (out_hs) begin
      valid_d = 1'b0;
    end
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (in_hs) begin
      if (last) begin
        // Slicing off the low bits is an arithmetic shift: floor toward -inf.
        data_d  = sum[LOG2_N +: DATA_W];
        valid_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = valid_q;
  assign blk_cnt       = cnt_q;

endmodule

// File: tb/tb_int_axis_block_averager.sv
// Randomised and directed checks of the block averager against a block-level arithmetic model.
module tb_int_axis_block_averager;

  localparam int unsigned DW = 32;
  localparam int unsigned LG = 2;
  localparam int NBLK = 4;

  logic          aclk;
  logic          aresetn;
  logic          clear;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [LG-1:0] blk_cnt;

  int_axis_block_averager #(
    .DATA_W(DW),
    .LOG2_N(LG)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .clear        (clear),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .blk_cnt      (blk_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: samples collected in the open block, and the mean waiting downstream.
  longint part_sum;
  int     part_cnt;
  bit     pend;
  longint pend_val;
  int     beats_exp;
  int     beats_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic longint floor_mean(input longint s);
    longint q;
    q = s / NBLK;
    if ((s % NBLK) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    part_sum = 0;
    part_cnt = 0;
    pend     = 1'b0;
    pend_val = 0;
  endtask

  // Drive one cycle, compare at the falling edge, advance the model to the next rising edge.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit rdy, input bit clr);
    bit exp_ready;
    bit in_hs;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    m_axis_tready = rdy;
    clear         = clr;
    #4;
    exp_ready = !(part_cnt == NBLK - 1 && pend && !rdy);
    check("s_tready", 64'(s_axis_tready), 64'(exp_ready));
    check("m_tvalid", 64'(m_axis_tvalid), 64'(pend));
    check("blk_cnt", 64'(blk_cnt), 64'(part_cnt));
    if (pend) check("m_tdata", 64'(m_axis_tdata), 64'(pend_val[DW-1:0]));
    if (m_axis_tvalid && m_axis_tready) beats_seen++;
    in_hs = v && exp_ready;
    if (pend && rdy) begin
      pend = 1'b0;
      beats_exp++;
    end
    if (clr) begin
      part_sum = 0;
      part_cnt = 0;
    end else if (in_hs) begin
      part_sum = part_sum + longint'($signed(d));
      part_cnt++;
      if (part_cnt == NBLK) begin
        pend     = 1'b1;
        pend_val = floor_mean(part_sum);
        part_sum = 0;
        part_cnt = 0;
      end
    end
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_sample();
    int sel;
    sel = $urandom_range(0, 5);
    case (sel)
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'(int'($urandom_range(0, 40)) - 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    model_reset();
    beats_exp     = 0;
    beats_seen    = 0;
    aresetn       = 1'b0;
    clear         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    #2;
    check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_blk_cnt", 64'(blk_cnt), 64'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // Basic mean and latency.
    cycle(1, 32'd1, 1, 0);
    cycle(1, 32'd2, 1, 0);
    cycle(1, 32'd3, 1, 0);
    cycle(1, 32'd6, 1, 0);
    check("basic_mean", 64'(m_axis_tdata), 64'd3);
    cycle(0, '0, 1, 0);

    // Negative sums floor toward -inf.
    cycle(1, 32'hFFFF_FFFF, 1, 0);
    cycle(1, 32'hFFFF_FFFE, 1, 0);
    cycle(1, 32'hFFFF_FFFE, 1, 0);
    cycle(1, 32'hFFFF_FFFE, 1, 0);
    check("neg_floor", 64'(m_axis_tdata), 64'h0000_0000_FFFF_FFFE);

    // Extremes must not overflow the accumulator.
    for (int i = 0; i < 4; i++) cycle(1, 32'h7FFF_FFFF, 1, 0);
    check("max_mean", 64'(m_axis_tdata), 64'h0000_0000_7FFF_FFFF);
    for (int i = 0; i < 4; i++) cycle(1, 32'h8000_0000, 1, 0);
    check("min_mean", 64'(m_axis_tdata), 64'h0000_0000_8000_0000);
    cycle(0, '0, 1, 0);

    // Backpressure: the 8th sample stalls, then completes on the same edge the first mean leaves.
    for (int i = 0; i < 8; i++) cycle(1, 32'd5, 0, 0);
    check("bp_stall", 64'(s_axis_tready), 64'd0);
    cycle(1, 32'd5, 1, 0);
    check("bp_second", 64'(m_axis_tvalid), 64'd1);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);

    // Clear discards a partial block.
    cycle(1, 32'd100, 1, 0);
    cycle(1, 32'd100, 1, 0);
    cycle(1, 32'd100, 1, 1);
    for (int i = 0; i < 4; i++) cycle(1, 32'd8, 1, 0);
    check("clear_mean", 64'(m_axis_tdata), 64'd8);

    // Reset with a mean pending drops it immediately.
    for (int i = 0; i < 4; i++) cycle(1, 32'd9, 0, 0);
    cycle(1, 32'd9, 0, 0);
    aresetn = 1'b0;
    #1;
    check("async_rst_valid", 64'(m_axis_tvalid), 64'd0);
    check("async_rst_cnt", 64'(blk_cnt), 64'd0);
    model_reset();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0);

    // Randomised traffic with backpressure and occasional clear.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), rand_sample(), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 40) == 0));
    end
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0);
    check("beat_count", 64'(beats_seen), 64'(beats_exp));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
